// File: rtl/vscale_fetch_unit_pkg.sv
// Shared constants, types and helpers for the vscale instruction-fetch front end.
package vscale_fetch_unit_pkg;

    localparam int          VSCALE_XPR_LEN    = 32;
    localparam int          VSCALE_INST_WIDTH = 32;
    localparam int          FETCH_QDEPTH      = 4;
    localparam logic [31:0] RV_NOP            = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsbs);
        return (pc_lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/vscale_fetch_unit_if.sv
// Instruction-memory read port: in-order request/response bus between fetch unit and imem.
interface vscale_fetch_unit_if
    import vscale_fetch_unit_pkg::*;
#(
    parameter int AW = VSCALE_XPR_LEN,
    parameter int DW = VSCALE_INST_WIDTH
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] addr;
    logic          resp_valid;
    logic [DW-1:0] rdata;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  resp_valid,
        input  rdata
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output resp_valid,
        output rdata
    );
endinterface

// File: rtl/vscale_fetch_queue.sv
// Synchronous FIFO with flush; a flush may load one entry in the same cycle.
module vscale_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // push at full is legal only when the head leaves in the same cycle
    assign w_do_pop  = i_pop && (r_count != {CW{1'b0}});
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_flush) begin
            r_rptr  <= {PW{1'b0}};
            r_wptr  <= i_push ? PW'(1) : {PW{1'b0}};
            r_count <= i_push ? CW'(1) : {CW{1'b0}};
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
        end else if (i_flush) begin
            if (i_push) r_mem[0] <= i_push_data;
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/vscale_fetch_unit.sv
// Instruction-fetch front end: issues imem reads, buffers responses, squashes stale ones on redirect.
// Optional macro VSCALE_FETCH_MISALIGN_TRAP_EN: misaligned redirects produce a fault marker and halt fetch.
module vscale_fetch_unit
    import vscale_fetch_unit_pkg::*;
#(
    parameter int QDEPTH  = FETCH_QDEPTH,
    parameter int XPR_LEN = VSCALE_XPR_LEN
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [XPR_LEN-1:0]           reset_vector,
    input  logic                         redirect,
    input  logic [XPR_LEN-1:0]           redirect_pc,
    vscale_fetch_unit_if.master          imem,
    output logic                         inst_valid_IF,
    output logic [XPR_LEN-1:0]           PC_IF,
    output logic [VSCALE_INST_WIDTH-1:0] inst_IF,
    input  logic                         stall_IF,
    output logic                         fetch_fault_IF
);
    localparam int                 CW       = $clog2(QDEPTH) + 1;
    localparam int                 EW       = 1 + XPR_LEN + VSCALE_INST_WIDTH;
    localparam logic [CW-1:0]      QDEPTH_C = CW'(QDEPTH);
    localparam logic [XPR_LEN-1:0] PC_STEP  = XPR_LEN'(4);
    localparam logic [XPR_LEN-1:0] LSB_MASK = ~(XPR_LEN'(3));
`ifdef VSCALE_FETCH_MISALIGN_TRAP_EN
    localparam logic               FAULT_EN = 1'b1;
`else
    localparam logic               FAULT_EN = 1'b0;
`endif

    fetch_state_e       r_state;
    logic               r_started;
    logic [XPR_LEN-1:0] r_fetch_pc;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      r_drop;

    logic [XPR_LEN-1:0] w_fetch_pc;
    logic [XPR_LEN-1:0] w_redirect_pc;
    logic               w_misalign;
    logic [CW-1:0]      w_data_count;
    logic [CW-1:0]      w_tag_count;
    logic [CW-1:0]      w_inflight;
    logic [CW-1:0]      w_out_next;
    logic               w_req_valid;
    logic               w_accept;
    logic               w_resp_keep;
    logic               w_tag_pop;
    logic               w_data_push;
    logic               w_data_pop;
    logic [EW-1:0]      w_data_in;
    logic [EW-1:0]      w_head;
    logic [XPR_LEN-1:0] w_tag_head;

    // reset_vector is used directly until the first accept/redirect moves the PC register
    assign w_fetch_pc    = r_started ? r_fetch_pc : reset_vector;
    assign w_redirect_pc = FAULT_EN ? redirect_pc : (redirect_pc & LSB_MASK);
    assign w_misalign    = FAULT_EN & redirect & pc_misaligned(redirect_pc[1:0]);

    // outstanding includes squashed fetches, so the cap also bounds drop
    assign w_inflight  = r_outstanding + w_data_count;
    assign w_req_valid = reset_n && (r_state == FETCH_RUN) && !redirect && (w_inflight < QDEPTH_C);
    assign w_accept    = w_req_valid && imem.req_ready;
    assign w_resp_keep = imem.resp_valid && (r_drop == {CW{1'b0}});
    assign w_tag_pop   = w_resp_keep && (w_tag_count != {CW{1'b0}});
    assign w_out_next  = r_outstanding + CW'(w_accept) - CW'(imem.resp_valid);

    assign w_data_push = redirect ? w_misalign : w_resp_keep;
    assign w_data_in   = redirect ? {1'b1, w_redirect_pc, RV_NOP} : {1'b0, w_tag_head, imem.rdata};
    assign w_data_pop  = inst_valid_IF && !stall_IF;

    vscale_fetch_queue #(.WIDTH(EW), .DEPTH(QDEPTH)) u_data_q (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (redirect),
        .i_push      (w_data_push),
        .i_push_data (w_data_in),
        .i_pop       (w_data_pop),
        .o_head      (w_head),
        .o_count     (w_data_count)
    );

    vscale_fetch_queue #(.WIDTH(XPR_LEN), .DEPTH(QDEPTH)) u_tag_q (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (redirect),
        .i_push      (w_accept),
        .i_push_data (w_fetch_pc),
        .i_pop       (w_tag_pop),
        .o_head      (w_tag_head),
        .o_count     (w_tag_count)
    );

    // Fetch sequencer: PC, run/halt state, in-flight and squash counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= FETCH_RUN;
            r_started     <= 1'b0;
            r_fetch_pc    <= {XPR_LEN{1'b0}};
            r_outstanding <= {CW{1'b0}};
            r_drop        <= {CW{1'b0}};
        end else begin
            r_outstanding <= w_out_next;
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_started  <= 1'b1;
                r_drop     <= w_out_next;
                r_state    <= w_misalign ? FETCH_HALT : FETCH_RUN;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= w_fetch_pc + PC_STEP;
                    r_started  <= 1'b1;
                end
                if (imem.resp_valid && (r_drop != {CW{1'b0}})) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    assign imem.req_valid = w_req_valid;
    assign imem.addr      = w_fetch_pc;
    assign inst_valid_IF  = (w_data_count != {CW{1'b0}});
    assign PC_IF          = inst_valid_IF ? w_head[EW-2 -: XPR_LEN] : w_fetch_pc;
    assign inst_IF        = inst_valid_IF ? w_head[VSCALE_INST_WIDTH-1:0] : RV_NOP;
    assign fetch_fault_IF = FAULT_EN & inst_valid_IF & w_head[EW-1];

endmodule
